icache_nway: RTL and testbench
==============================

ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 Parameter AXI_ID, default 0, AXI read ID driven on axi_arid_o and matched against axi_rid_i.
REQ-002 Parameter NUM_WAYS, default 2, associativity; power of 2 in 1..8.
REQ-003 Parameter NUM_LINES, default 256, sets per way; power of 2, at least 2.
REQ-004 Parameter LINE_WORDS, default 8, 32-bit words per line; power of 2, at least 2.
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 req_rd_i  in  1  fetch request.
REQ-008 req_flush_i  in  1  invalidate entire cache.
REQ-009 req_invalidate_i  in  1  invalidate set indexed by req_pc_i, all ways.
REQ-010 req_pc_i  in  32  fetch address, 8-byte aligned.
REQ-011 req_accept_o  out  1  request taken this cycle.
REQ-012 req_valid_o  out  1  response valid.
REQ-013 req_error_o  out  1  response is a bus error; only with req_valid_o.
REQ-014 req_inst_o  out  64  two instructions at the 8-byte-aligned address.
REQ-015 axi_arvalid_o out 1; axi_araddr_o out 32; axi_arid_o out 4; axi_arlen_o out 8; axi_arburst_o out 2; axi_arready_i in 1: AXI read address channel.
REQ-016 axi_rdata_i in 32; axi_rresp_i in 2; axi_rid_i in 4; axi_rlast_i in 1; axi_rvalid_i in 1; axi_rready_o out 1: AXI read data channel.

Function
REQ-017 Address split: offset = log2(LINE_WORDS*4) bits, index = log2(NUM_LINES) bits, tag = remaining upper bits; tag entry = tag plus valid bit.
REQ-018 States FLUSH, LOOKUP, REFILL, RELOOKUP; after reset, state = FLUSH with flush counter = 0.
REQ-019 FLUSH (full): write an invalid tag to all ways at counter index, one set per cycle; go to LOOKUP after index NUM_LINES-1 (NUM_LINES cycles in total).
REQ-020 FLUSH (single, from invalidate): one cycle; write invalid to all ways of the captured index; go to LOOKUP.
REQ-021 req_accept_o = 1 in LOOKUP unless the pending lookup misses this cycle; an accepted request is captured and its tag/data RAMs are read the same cycle.
REQ-022 Hit: req_valid_o = 1 the cycle after accept, req_inst_o from the hit way (lowest way index wins), req_error_o = 0; back-to-back hits sustain one per cycle.
REQ-023 Miss: go LOOKUP->REFILL; axi_arvalid_o = 1 with araddr = line-aligned lookup address, arlen = LINE_WORDS-1, arburst = INCR, arid = AXI_ID; arvalid held until arready is sampled high.
REQ-024 Victim = lowest-index invalid way in the set; if no way is invalid, use a global round-robin pointer that advances by one (mod NUM_WAYS) on each completed refill that used it.
REQ-025 axi_rready_o = 1 always; ignore beats when state != REFILL or rid != AXI_ID.
REQ-026 Beat packing: even beat is latched as the low half; odd beat writes {odd, even} as 64 bits to the victim data RAM at the next line slot; slot counter wraps to 0 on rlast.
REQ-027 Record any beat with rresp != 0 as a refill error.
REQ-028 On rlast: write victim tag valid=1 if no error, valid=0 if error; go to RELOOKUP.
REQ-029 RELOOKUP: re-read RAMs at the captured address; go to LOOKUP.
REQ-030 After RELOOKUP without error, the following LOOKUP cycle asserts req_valid_o with the hit data.
REQ-031 After RELOOKUP with error, the following LOOKUP cycle asserts req_valid_o=1, req_error_o=1, req_inst_o=0, and clears the error.
REQ-032 In LOOKUP with no pending miss: req_flush_i selects full FLUSH; else req_invalidate_i selects single FLUSH; if both are asserted, flush wins; a pending miss takes priority over both.
REQ-033 NUM_WAYS=1 degenerates to direct-mapped with no pointer logic.

Reset
REQ-034 Asynchronous assertion forces state=FLUSH, flush counter=0, round-robin pointer=0, all captured and error state cleared.
REQ-035 During and after reset: req_accept_o=0, req_valid_o=0, req_error_o=0, req_inst_o=0, axi_arvalid_o=0; reset mid-refill abandons the line, and stray beats are ignored per REQ-025.

Structure
REQ-036 Package icache_pkg holds the state encoding, derived widths (offset/index/tag, data-RAM address), and the AXI burst/response constants.
REQ-037 Sub-module icache_nway_way: one tag RAM plus one 64-bit data RAM with per-way hit compare; generated NUM_WAYS times.

Verification
REQ-038 Reset, then fetch 0x1000 -> no accept for 256 cycles; miss; AR addr 0x1000, len 7; 8 beats; req_valid_o with words 1,0 packed as {w1,w0}.
REQ-039 Fetch 0x1008 twice after fill -> each hit returns {w3,w2} one cycle after accept, no AXI traffic.
REQ-040 2-way: fill 0x1000, 0x3000, 0x5000 (same set) -> ways 0 then 1 filled via invalid-first; third refill evicts way 0 (pointer=0); refetch 0x3000 hits.
REQ-041 Refill with rresp=2 on beat 3 -> response req_error_o=1, inst=0; refetch of the same address misses again.
REQ-042 req_invalidate_i at 0x1000 -> one-cycle FLUSH; 0x1000 misses; a line in another set still hits; flush+invalidate together -> 256-cycle flush.
REQ-043 Assert rstn_i low during beat 4 -> outputs go to 0; remaining beats are ignored; FLUSH completes cleanly.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the n-way instruction cache.
// The width helpers keep address slicing consistent between the top level and the ways.
package icache_pkg;

    typedef enum logic [1:0] {
        STATE_FLUSH    = 2'd0,
        STATE_LOOKUP   = 2'd1,
        STATE_REFILL   = 2'd2,
        STATE_RELOOKUP = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int ofs_width(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int idx_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int line_words, input int num_lines);
        return 32 - ofs_width(line_words) - idx_width(num_lines);
    endfunction

    // A data RAM entry is one 64-bit pair, so its address is pc[idx+ofs-1:3].
    function automatic int daddr_width(input int line_words, input int num_lines);
        return idx_width(num_lines) + ofs_width(line_words) - 3;
    endfunction

endpackage

// File: rtl/icache_nway_way.sv
// One cache way: tag RAM ({valid, tag}) and 64-bit data RAM, both read synchronously.
// Hit is resolved combinationally against the registered tag read.
module icache_nway_way #(
    parameter int TAG_W   = 19,
    parameter int IDX_W   = 8,
    parameter int DADDR_W = 10
) (
    input  logic               clk_i,
    input  logic [IDX_W-1:0]   tag_raddr,
    input  logic [DADDR_W-1:0] data_raddr,
    input  logic [TAG_W-1:0]   cmp_tag,
    input  logic               tag_we,
    input  logic [IDX_W-1:0]   tag_waddr,
    input  logic [TAG_W:0]     tag_wdata,
    input  logic               data_we,
    input  logic [DADDR_W-1:0] data_waddr,
    input  logic [63:0]        data_wdata,
    output logic               line_vld,
    output logic               hit,
    output logic [63:0]        rdata
);

    logic [TAG_W:0] tag_ram [2**IDX_W];
    logic [63:0]    data_ram [2**DADDR_W];
    logic [TAG_W:0] tag_q;

    always_ff @(posedge clk_i) begin
        if (tag_we) begin
            tag_ram[tag_waddr] <= tag_wdata;
        end
        tag_q <= tag_ram[tag_raddr];
    end

    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_ram[data_waddr] <= data_wdata;
        end
        rdata <= data_ram[data_raddr];
    end

    assign line_vld = tag_q[TAG_W];
    assign hit      = tag_q[TAG_W] && (tag_q[TAG_W-1:0] == cmp_tag);

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with AXI burst refill, 64-bit fetch port.
// Hits respond one cycle after accept; a miss holds off accept until the refilled line is re-read.
module icache_nway
    import icache_pkg::*;
#(
    parameter int AXI_ID     = 0,
    parameter int NUM_WAYS   = 2,
    parameter int NUM_LINES  = 256,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_rd_i,
    input  logic        req_flush_i,
    input  logic        req_invalidate_i,
    input  logic [31:0] req_pc_i,
    output logic        req_accept_o,
    output logic        req_valid_o,
    output logic        req_error_o,
    output logic [63:0] req_inst_o,
    output logic        axi_arvalid_o,
    output logic [31:0] axi_araddr_o,
    output logic [3:0]  axi_arid_o,
    output logic [7:0]  axi_arlen_o,
    output logic [1:0]  axi_arburst_o,
    input  logic        axi_arready_i,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    input  logic [3:0]  axi_rid_i,
    input  logic        axi_rlast_i,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o
);

    localparam int OFS_W   = ofs_width(LINE_WORDS);
    localparam int IDX_W   = idx_width(NUM_LINES);
    localparam int TAG_W   = tag_width(LINE_WORDS, NUM_LINES);
    localparam int DADDR_W = daddr_width(LINE_WORDS, NUM_LINES);
    localparam int SLOT_W  = OFS_W - 3;
    localparam int BEAT_W  = $clog2(LINE_WORDS);
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    flush_idx_q;
    logic                flush_single_q;
    logic                lookup_vld_q;
    logic [31:3]         lookup_addr_q;
    logic                refill_err_q;
    logic [WAY_W-1:0]    victim_q, rr_q;
    logic                victim_rr_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [31:0]         low_word_q;
    logic                arvalid_q;

    logic [NUM_WAYS-1:0] way_vld, way_hit, tag_we, data_we;
    logic [63:0]         way_dat [NUM_WAYS];
    logic [63:0]         hit_dat;
    logic                any_hit, miss, take, rsp, beat_ok, beat_last, beat_err;
    logic                free_found;
    logic [WAY_W-1:0]    free_way, victim_sel;
    logic [IDX_W-1:0]    tag_waddr, lookup_idx;
    logic [TAG_W:0]      tag_wdata;
    logic [TAG_W-1:0]    lookup_tag;
    logic [31:3]         rd_addr;
    logic [DADDR_W-1:0]  data_waddr;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^req_pc_i[2:0];

    assign lookup_idx = lookup_addr_q[OFS_W+IDX_W-1:OFS_W];
    assign lookup_tag = lookup_addr_q[31:OFS_W+IDX_W];

    // Lookup state classification; a returned refill error is answered, not re-missed.
    always_comb begin
        hit_dat = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_dat = way_dat[i];
            end
        end
        free_found = 1'b0;
        free_way   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!way_vld[i]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(i);
            end
        end
    end

    assign any_hit      = |way_hit;
    assign victim_sel   = free_found ? free_way : ((NUM_WAYS > 1) ? rr_q : '0);
    assign miss         = (state_q == STATE_LOOKUP) && lookup_vld_q && !any_hit && !refill_err_q;
    assign rsp          = (state_q == STATE_LOOKUP) && lookup_vld_q && (any_hit || refill_err_q);
    assign req_accept_o = (state_q == STATE_LOOKUP) && !miss && !req_flush_i && !req_invalidate_i;
    assign take         = req_accept_o && req_rd_i;
    assign req_valid_o  = rsp;
    assign req_error_o  = rsp && refill_err_q;
    assign req_inst_o   = (rsp && !refill_err_q) ? hit_dat : 64'h0;

    assign beat_ok   = axi_rvalid_i && (state_q == STATE_REFILL) && (axi_rid_i == 4'(AXI_ID));
    assign beat_last = beat_ok && axi_rlast_i;
    assign beat_err  = axi_rresp_i != AXI_RESP_OKAY;

    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = {lookup_addr_q[31:OFS_W], OFS_W'(0)};
    assign axi_arid_o    = 4'(AXI_ID);
    assign axi_arlen_o   = 8'(LINE_WORDS - 1);
    assign axi_arburst_o = AXI_BURST_INCR;
    assign axi_rready_o  = 1'b1;

    assign rd_addr    = take ? req_pc_i[31:3] : lookup_addr_q;
    assign data_waddr = (DADDR_W'(lookup_idx) << SLOT_W) | DADDR_W'(beat_q >> 1);

    always_comb begin
        tag_we    = '0;
        tag_waddr = flush_idx_q;
        tag_wdata = '0;
        data_we   = '0;
        if (state_q == STATE_FLUSH) begin
            tag_we = '1;
        end else if (beat_last) begin
            tag_we[victim_q] = 1'b1;
            tag_waddr        = lookup_idx;
            tag_wdata        = {!(refill_err_q || beat_err), lookup_tag};
        end
        if (beat_ok && beat_q[0]) begin
            data_we[victim_q] = 1'b1;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        icache_nway_way #(
            .TAG_W  (TAG_W),
            .IDX_W  (IDX_W),
            .DADDR_W(DADDR_W)
        ) u_way (
            .clk_i     (clk_i),
            .tag_raddr (rd_addr[OFS_W+IDX_W-1:OFS_W]),
            .data_raddr(rd_addr[OFS_W+IDX_W-1:3]),
            .cmp_tag   (lookup_tag),
            .tag_we    (tag_we[w]),
            .tag_waddr (tag_waddr),
            .tag_wdata (tag_wdata),
            .data_we   (data_we[w]),
            .data_waddr(data_waddr),
            .data_wdata({axi_rdata_i, low_word_q}),
            .line_vld  (way_vld[w]),
            .hit       (way_hit[w]),
            .rdata     (way_dat[w])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_FLUSH: begin
                if (flush_single_q || flush_idx_q == IDX_W'(NUM_LINES - 1)) begin
                    state_d = STATE_LOOKUP;
                end
            end
            STATE_LOOKUP: begin
                if (miss) begin
                    state_d = STATE_REFILL;
                end else if (req_flush_i || req_invalidate_i) begin
                    state_d = STATE_FLUSH;
                end
            end
            STATE_REFILL: begin
                if (beat_last) begin
                    state_d = STATE_RELOOKUP;
                end
            end
            default: state_d = STATE_LOOKUP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= STATE_FLUSH;
            flush_idx_q    <= '0;
            flush_single_q <= 1'b0;
            lookup_vld_q   <= 1'b0;
            lookup_addr_q  <= '0;
            refill_err_q   <= 1'b0;
            victim_q       <= '0;
            rr_q           <= '0;
            victim_rr_q    <= 1'b0;
            beat_q         <= '0;
            low_word_q     <= '0;
            arvalid_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                STATE_FLUSH: begin
                    if (state_d == STATE_LOOKUP) begin
                        flush_idx_q    <= '0;
                        flush_single_q <= 1'b0;
                    end else begin
                        flush_idx_q <= flush_idx_q + IDX_W'(1);
                    end
                end
                STATE_LOOKUP: begin
                    if (rsp) begin
                        refill_err_q <= 1'b0;
                    end
                    if (miss) begin
                        arvalid_q   <= 1'b1;
                        victim_q    <= victim_sel;
                        victim_rr_q <= !free_found;
                        beat_q      <= '0;
                    end else if (req_flush_i) begin
                        flush_idx_q    <= '0;
                        flush_single_q <= 1'b0;
                        lookup_vld_q   <= 1'b0;
                    end else if (req_invalidate_i) begin
                        flush_idx_q    <= req_pc_i[OFS_W+IDX_W-1:OFS_W];
                        flush_single_q <= 1'b1;
                        lookup_vld_q   <= 1'b0;
                    end else begin
                        lookup_vld_q <= take;
                        if (take) begin
                            lookup_addr_q <= req_pc_i[31:3];
                        end
                    end
                end
                STATE_REFILL: begin
                    if (arvalid_q && axi_arready_i) begin
                        arvalid_q <= 1'b0;
                    end
                    if (beat_ok) begin
                        if (!beat_q[0]) begin
                            low_word_q <= axi_rdata_i;
                        end
                        if (beat_err) begin
                            refill_err_q <= 1'b1;
                        end
                        if (axi_rlast_i) begin
                            beat_q <= '0;
                            if (NUM_WAYS > 1 && victim_rr_q) begin
                                rr_q <= rr_q + WAY_W'(1);
                            end
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Randomized self-checking bench for icache_nway against a set/way occupancy model
// and an address-hashed backing memory.
module tb_icache_nway;

    localparam int NW     = 2;
    localparam int NL     = 256;
    localparam int LW     = 8;
    localparam int AXI_ID = 0;
    localparam int OFS    = $clog2(LW * 4);
    localparam int IDXW   = $clog2(NL);

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_rd_i = 1'b0, req_flush_i = 1'b0, req_invalidate_i = 1'b0;
    logic [31:0] req_pc_i = '0;
    logic        req_accept_o, req_valid_o, req_error_o;
    logic [63:0] req_inst_o;
    logic        axi_arvalid_o, axi_arready_i = 1'b0;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic [31:0] axi_rdata_i = '0;
    logic [1:0]  axi_rresp_i = '0;
    logic [3:0]  axi_rid_i = '0;
    logic        axi_rlast_i = 1'b0, axi_rvalid_i = 1'b0, axi_rready_o;

    always #5 clk_i = ~clk_i;

    icache_nway #(.AXI_ID(AXI_ID), .NUM_WAYS(NW), .NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_rd_i(req_rd_i), .req_flush_i(req_flush_i),
        .req_invalidate_i(req_invalidate_i), .req_pc_i(req_pc_i), .req_accept_o(req_accept_o),
        .req_valid_o(req_valid_o), .req_error_o(req_error_o), .req_inst_o(req_inst_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
        .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o), .axi_arready_i(axi_arready_i),
        .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i), .axi_rid_i(axi_rid_i),
        .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
    );

    int          checks = 0;
    int          fails = 0;
    logic [31:0] seed;
    bit          mv [NL][NW];
    int unsigned mt [NL][NW];
    int          rr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> OFS) % NL);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a >> (OFS + IDXW);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        for (int w = 0; w < NW; w++)
            if (mv[set_of(a)][w] && mt[set_of(a)][w] == tag_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_fill(input logic [31:0] a, input bit err);
        int v = -1;
        for (int w = NW - 1; w >= 0; w--) if (!mv[set_of(a)][w]) v = w;
        if (v < 0) begin
            v  = rr;
            rr = (rr + 1) % NW;
        end
        mv[set_of(a)][v] = !err;
        mt[set_of(a)][v] = tag_of(a);
    endtask

    task automatic m_clear();
        for (int s = 0; s < NL; s++) for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
    endtask

    // Counts rising edges spent in FLUSH until accept reappears.
    task automatic flush_len(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk_i);
            cnt++;
            @(negedge clk_i);
        end while (!req_accept_o && cnt < 1000);
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp, input bit last);
        @(negedge clk_i);
        axi_rvalid_i = 1'b1; axi_rdata_i = d; axi_rid_i = id; axi_rresp_i = resp; axi_rlast_i = last;
        @(posedge clk_i);
        #1 axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0; axi_rresp_i = 2'b00;
    endtask

    task automatic fetch(input logic [31:0] addr, input int err_beat);
        bit          exp_hit, err;
        int          n;
        logic [63:0] exp_inst;
        logic [31:0] base;
        exp_hit  = m_hit(addr);
        exp_inst = {mem(addr + 32'd4), mem(addr)};
        base     = addr & ~32'(LW * 4 - 1);
        @(negedge clk_i);
        req_rd_i = 1'b1; req_pc_i = addr;
        n = 0;
        while (!req_accept_o && n < 200) begin @(negedge clk_i); n++; end
        checks++;
        if (n >= 200) begin fails++; $display("FAIL accept_timeout addr=%h waited=%0d cycles", addr, n); end
        @(posedge clk_i);
        #1 req_rd_i = 1'b0;
        @(negedge clk_i);
        if (exp_hit) begin
            checks++;
            if (req_valid_o !== 1'b1 || req_error_o !== 1'b0 || req_inst_o !== exp_inst || axi_arvalid_o !== 1'b0) begin
                fails++;
                $display("FAIL hit_rsp addr=%h got v=%b e=%b inst=%h ar=%b want v=1 e=0 inst=%h ar=0",
                         addr, req_valid_o, req_error_o, req_inst_o, axi_arvalid_o, exp_inst);
            end
        end else begin
            checks++;
            if (req_valid_o !== 1'b0) begin fails++; $display("FAIL miss_early_valid addr=%h got %b want 0", addr, req_valid_o); end
            n = 0;
            while (!axi_arvalid_o && n < 20) begin @(negedge clk_i); n++; end
            checks++;
            if (n >= 20 || axi_araddr_o !== base || axi_arlen_o !== 8'(LW - 1) || axi_arburst_o !== 2'b01 ||
                axi_arid_o !== 4'(AXI_ID) || req_accept_o !== 1'b0) begin
                fails++;
                $display("FAIL ar_req got addr=%h len=%0d burst=%b id=%0d acc=%b want addr=%h len=%0d burst=01 id=%0d acc=0",
                         axi_araddr_o, axi_arlen_o, axi_arburst_o, axi_arid_o, req_accept_o, base, LW - 1, AXI_ID);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            checks++;
            if (axi_arvalid_o !== 1'b1) begin fails++; $display("FAIL ar_hold got %b want 1", axi_arvalid_o); end
            axi_arready_i = 1'b1;
            @(posedge clk_i);
            #1 axi_arready_i = 1'b0;
            for (int i = 0; i < LW; i++) begin
                if ($urandom_range(0, 7) == 0)
                    drive_beat($urandom, 4'(AXI_ID + 1), 2'b10, 1'b1);
                drive_beat(mem(base + 32'(4 * i)), 4'(AXI_ID), (i == err_beat) ? 2'b10 : 2'b00, i == LW - 1);
            end
            err = (err_beat >= 0);
            m_fill(addr, err);
            n = 0;
            @(negedge clk_i);
            while (!req_valid_o && n < 20) begin @(negedge clk_i); n++; end
            checks++;
            if (n >= 20 || req_error_o !== err || req_inst_o !== (err ? 64'h0 : exp_inst) || axi_arvalid_o !== 1'b0) begin
                fails++;
                $display("FAIL refill_rsp addr=%h got v=%b e=%b inst=%h ar=%b want v=1 e=%b inst=%h ar=0",
                         addr, req_valid_o, req_error_o, req_inst_o, axi_arvalid_o, err, err ? 64'h0 : exp_inst);
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({req_accept_o, req_valid_o, req_error_o, axi_arvalid_o} !== 4'b0 || req_inst_o !== 64'h0) begin
            fails++;
            $display("FAIL reset_outputs got acc=%b v=%b e=%b ar=%b inst=%h want all 0",
                     req_accept_o, req_valid_o, req_error_o, axi_arvalid_o, req_inst_o);
        end
        req_rd_i = 1'b1; req_pc_i = 32'h1000;
        rstn_i = 1'b1;
        flush_len(cnt);
        req_rd_i = 1'b0;
        checks++;
        if (cnt !== NL) begin fails++; $display("FAIL reset_flush_len got %0d want %0d", cnt, NL); end
        m_clear(); rr = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [6] = '{32'h1000, 32'h1008, 32'h1010, 32'h1018, 32'h1008, 32'h1000};
        fetch(32'h1000, -1);
        @(negedge clk_i);
        req_rd_i = 1'b1; req_pc_i = a[0];
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            checks++;
            if (req_valid_o !== 1'b1 || req_inst_o !== {mem(a[i-1] + 32'd4), mem(a[i-1])} || req_accept_o !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d] got v=%b acc=%b inst=%h want v=1 acc=1 inst=%h", i - 1,
                         req_valid_o, req_accept_o, req_inst_o, {mem(a[i-1] + 32'd4), mem(a[i-1])});
            end
            if (i < 6) req_pc_i = a[i];
            else req_rd_i = 1'b0;
        end
    endtask

    task automatic test_ways();
        fetch(32'h1000, -1);
        fetch(32'h3000, -1);
        fetch(32'h5000, -1);
        fetch(32'h3000, -1);
        fetch(32'h1000, -1);
        fetch(32'h5000, -1);
    endtask

    task automatic test_error();
        fetch(32'h2000, 3);
        fetch(32'h2000, -1);
        fetch(32'h2008, -1);
    endtask

    task automatic test_invalidate();
        int cnt;
        fetch(32'h4020, -1);
        fetch(32'h1000, -1);
        @(negedge clk_i);
        req_invalidate_i = 1'b1; req_pc_i = 32'h1000;
        @(posedge clk_i);
        #1 req_invalidate_i = 1'b0;
        flush_len(cnt);
        checks++;
        if (cnt !== 1) begin fails++; $display("FAIL inval_len got %0d want 1", cnt); end
        for (int w = 0; w < NW; w++) mv[set_of(32'h1000)][w] = 1'b0;
        fetch(32'h1000, -1);
        fetch(32'h4020, -1);
        @(negedge clk_i);
        req_invalidate_i = 1'b1; req_flush_i = 1'b1;
        @(posedge clk_i);
        #1 req_invalidate_i = 1'b0; req_flush_i = 1'b0;
        flush_len(cnt);
        checks++;
        if (cnt !== NL) begin fails++; $display("FAIL flush_len got %0d want %0d", cnt, NL); end
        m_clear();
        fetch(32'h4020, -1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          cnt;
        for (int k = 0; k < 40; k++) begin
            a = 32'h2_0000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 3) * 32'h2000)
                + 32'($urandom_range(0, 3) * 8);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk_i);
                req_invalidate_i = 1'b1; req_pc_i = a;
                @(posedge clk_i);
                #1 req_invalidate_i = 1'b0;
                flush_len(cnt);
                checks++;
                if (cnt !== 1) begin fails++; $display("FAIL rand_inval_len got %0d want 1", cnt); end
                for (int w = 0; w < NW; w++) mv[set_of(a)][w] = 1'b0;
            end
            fetch(a, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1);
        end
    endtask

    task automatic test_reset_mid_refill();
        int n, cnt, i;
        fetch(32'h0000_ABC0, -1);
        @(negedge clk_i);
        req_invalidate_i = 1'b1; req_pc_i = 32'h0000_ABC0;
        @(posedge clk_i);
        #1 req_invalidate_i = 1'b0;
        flush_len(cnt);
        @(negedge clk_i);
        req_rd_i = 1'b1; req_pc_i = 32'h0000_ABC0;
        @(posedge clk_i);
        #1 req_rd_i = 1'b0;
        n = 0;
        while (!axi_arvalid_o && n < 20) begin @(negedge clk_i); n++; end
        checks++;
        if (n >= 20) begin fails++; $display("FAIL mid_ar_timeout waited=%0d want <20", n); end
        axi_arready_i = 1'b1;
        @(posedge clk_i);
        #1 axi_arready_i = 1'b0;
        for (int b = 0; b < 4; b++) drive_beat(mem(32'h0000_ABC0 + 32'(4 * b)), 4'(AXI_ID), 2'b00, 1'b0);
        @(negedge clk_i);
        axi_rvalid_i = 1'b1; axi_rdata_i = mem(32'h0000_ABD0); axi_rid_i = 4'(AXI_ID);
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if ({req_accept_o, req_valid_o, req_error_o, axi_arvalid_o} !== 4'b0 || req_inst_o !== 64'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs got acc=%b v=%b e=%b ar=%b inst=%h want all 0",
                     req_accept_o, req_valid_o, req_error_o, axi_arvalid_o, req_inst_o);
        end
        @(posedge clk_i);
        #1 axi_rvalid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        cnt = 0; i = 5;
        do begin
            if (i < LW) begin
                axi_rvalid_i = 1'b1; axi_rdata_i = $urandom; axi_rlast_i = (i == LW - 1);
                i++;
            end
            @(posedge clk_i);
            cnt++;
            #1 axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
            @(negedge clk_i);
        end while (!req_accept_o && cnt < 1000);
        checks++;
        if (cnt !== NL) begin fails++; $display("FAIL mid_reset_flush_len got %0d want %0d", cnt, NL); end
        m_clear(); rr = 0;
        fetch(32'h0000_ABC0, -1);
        fetch(32'h0000_ABC8, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seed = $urandom;
        rr   = 0;
        m_clear();
        test_reset();
        fetch(32'h1000, -1);
        fetch(32'h1008, -1);
        fetch(32'h1008, -1);
        test_back_to_back();
        test_ways();
        test_error();
        test_invalidate();
        test_random();
        test_reset_mid_refill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
